// File: rtl/mem_port_arb.sv
// Single-port memory arbiter: fetch vs. data requester, fixed-latency memory, registered responses.
// Optional fetch-starvation guard enabled by defining MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arb #(
    parameter int unsigned MEM_LAT         = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_p1,
    input  logic [15:0] if_addr_p1,
    input  logic        if_flush_p1,
    output logic        if_gnt_p1,
    output logic        if_rvalid_p1,
    output logic [15:0] if_rdata_p1,
    input  logic        ls_req_p1,
    input  logic        ls_store_p1,
    input  logic [15:0] ls_addr_p1,
    input  logic [15:0] ls_wdata_p1,
    output logic        ls_gnt_p1,
    output logic        ls_rvalid_p1,
    output logic [15:0] ls_rdata_p1,
    output logic        mem_en_p1,
    output logic        mem_wr_p1,
    output logic [15:0] mem_addr_p1,
    output logic [15:0] mem_wdata_p1,
    input  logic [15:0] mem_rdata_p1,
    output logic        busy_p1
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic owner_ls;
        logic store;
    } owner_t;

    state_t          r_state, w_state_nxt;
    owner_t          r_own, w_own_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_kill, w_kill_nxt;
    logic            r_if_rvalid, w_if_rvalid_nxt;
    logic [DW-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic            r_ls_rvalid, w_ls_rvalid_nxt;
    logic [DW-1:0]   r_ls_rdata, w_ls_rdata_nxt;
    logic            r_mem_en, w_mem_en_nxt;
    logic            r_mem_wr, w_mem_wr_nxt;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic            r_busy, w_busy_nxt;
    logic            w_arb, w_force_if, w_gnt_if, w_gnt_ls;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam int unsigned SW = 4;
    logic [SW-1:0]   r_streak, w_streak_nxt;
`endif

    // Arbitration: data first unless the streak guard hands the slot to fetch
    always_comb begin
        w_arb = (r_state == S_IDLE) || (r_state == S_RESP);
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
        w_force_if = (r_streak == SW'(MAX_DATA_STREAK)) && if_req_p1 && ls_req_p1;
`else
        w_force_if = 1'b0;
`endif
        w_gnt_ls = w_arb && ls_req_p1 && !w_force_if;
        w_gnt_if = w_arb && if_req_p1 && !w_gnt_ls;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_own_nxt       = r_own;
        w_cnt_nxt       = r_cnt;
        w_kill_nxt      = r_kill;
        w_if_rvalid_nxt = 1'b0;
        w_if_rdata_nxt  = '0;
        w_ls_rvalid_nxt = 1'b0;
        w_ls_rdata_nxt  = '0;
        w_mem_en_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;

        case (r_state)
            S_ISSUE: begin
                w_cnt_nxt   = CW'(MEM_LAT);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_RESP;
                    if (r_own.owner_ls) begin
                        w_ls_rvalid_nxt = 1'b1;
                        w_ls_rdata_nxt  = r_own.store ? '0 : mem_rdata_p1;
                    end else if (!(r_kill || if_flush_p1)) begin
                        // a flush in this very cycle must also squash the response
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = mem_rdata_p1;
                    end
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: ;
        endcase

        if (r_state != S_IDLE && !r_own.owner_ls && if_flush_p1) begin
            w_kill_nxt = 1'b1;
        end

        // A new grant launches the access; the kill flag belongs to the old owner
        if (w_gnt_ls || w_gnt_if) begin
            w_state_nxt        = S_ISSUE;
            w_own_nxt.owner_ls = w_gnt_ls;
            w_own_nxt.store    = w_gnt_ls && ls_store_p1;
            w_kill_nxt         = 1'b0;
            w_mem_en_nxt       = 1'b1;
            w_mem_wr_nxt       = w_gnt_ls && ls_store_p1;
            w_mem_addr_nxt     = w_gnt_ls ? ls_addr_p1 : if_addr_p1;
            w_mem_wdata_nxt    = (w_gnt_ls && ls_store_p1) ? ls_wdata_p1 : '0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    // Streak counts data grants taken while fetch was waiting
    always_comb begin
        w_streak_nxt = r_streak;
        if (w_arb) begin
            if (w_gnt_if || !if_req_p1) begin
                w_streak_nxt = '0;
            end else if (w_gnt_ls) begin
                w_streak_nxt = r_streak + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_own       <= '0;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_own       <= w_own_nxt;
            r_cnt       <= w_cnt_nxt;
            r_kill      <= w_kill_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_ls_rvalid <= w_ls_rvalid_nxt;
            r_ls_rdata  <= w_ls_rdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign if_gnt_p1    = w_gnt_if;
    assign ls_gnt_p1    = w_gnt_ls;
    assign if_rvalid_p1 = r_if_rvalid;
    assign if_rdata_p1  = r_if_rdata;
    assign ls_rvalid_p1 = r_ls_rvalid;
    assign ls_rdata_p1  = r_ls_rdata;
    assign mem_en_p1    = r_mem_en;
    assign mem_wr_p1    = r_mem_wr;
    assign mem_addr_p1  = r_mem_addr;
    assign mem_wdata_p1 = r_mem_wdata;
    assign busy_p1      = r_busy;

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: fixed-latency memory model plus reference memory for expected data.
module tb_mem_port_arb;

    localparam int unsigned MEM_LAT    = 3;
    localparam int unsigned MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_p1 = 1'b0, if_flush_p1 = 1'b0;
    logic [15:0] if_addr_p1 = '0;
    logic        ls_req_p1 = 1'b0, ls_store_p1 = 1'b0;
    logic [15:0] ls_addr_p1 = '0, ls_wdata_p1 = '0;
    logic        if_gnt_p1, if_rvalid_p1, ls_gnt_p1, ls_rvalid_p1;
    logic [15:0] if_rdata_p1, ls_rdata_p1;
    logic        mem_en_p1, mem_wr_p1, busy_p1;
    logic [15:0] mem_addr_p1, mem_wdata_p1, mem_rdata_p1;

    always #5 clk = ~clk;

    mem_port_arb #(.MEM_LAT(MEM_LAT), .MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req_p1(if_req_p1), .if_addr_p1(if_addr_p1), .if_flush_p1(if_flush_p1),
        .if_gnt_p1(if_gnt_p1), .if_rvalid_p1(if_rvalid_p1), .if_rdata_p1(if_rdata_p1),
        .ls_req_p1(ls_req_p1), .ls_store_p1(ls_store_p1), .ls_addr_p1(ls_addr_p1),
        .ls_wdata_p1(ls_wdata_p1), .ls_gnt_p1(ls_gnt_p1), .ls_rvalid_p1(ls_rvalid_p1),
        .ls_rdata_p1(ls_rdata_p1), .mem_en_p1(mem_en_p1), .mem_wr_p1(mem_wr_p1),
        .mem_addr_p1(mem_addr_p1), .mem_wdata_p1(mem_wdata_p1), .mem_rdata_p1(mem_rdata_p1),
        .busy_p1(busy_p1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h3C3C);
    endfunction

    // Memory model: read data valid exactly MEM_LAT cycles after the strobe, garbage otherwise
    logic [15:0] phys_mem [65536];
    logic        phys_w   [65536];
    logic [15:0] pipe     [MEM_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_en_p1 ? ((phys_w[mem_addr_p1] === 1'b1) ? phys_mem[mem_addr_p1]
                                                                : mem_init(mem_addr_p1))
                             : 16'hDEAD;
        for (int i = 1; i < int'(MEM_LAT); i++) pipe[i] <= pipe[i-1];
        if (mem_en_p1 && mem_wr_p1) begin
            phys_mem[mem_addr_p1] <= mem_wdata_p1;
            phys_w[mem_addr_p1]   <= 1'b1;
        end
    end
    assign mem_rdata_p1 = pipe[MEM_LAT-1];

    logic [15:0] ref_mem [65536];
    logic        ref_w   [65536];

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return (ref_w[a] === 1'b1) ? ref_mem[a] : mem_init(a);
    endfunction

    typedef struct { logic [15:0] data; int cyc; } exp_t;
    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } mev_t;
    exp_t exp_if_q[$];
    exp_t exp_ls_q[$];
    mev_t mem_q[$];

    int   checks = 0, errors = 0, mem_idle_bad = 0, both_gnt = 0, scyc = 0;
    logic sbusy;

    // Sample one cycle at negedge, score responses, then move to the next drive point
    task automatic step(output bit gi, output bit gl);
        exp_t e;
        @(negedge clk);
        scyc  = cyc;
        sbusy = busy_p1;
        gi    = if_gnt_p1;
        gl    = ls_gnt_p1;
        if (gi && gl) both_gnt++;
        if (!mem_en_p1 && (mem_wr_p1 || mem_addr_p1 != 16'h0 || mem_wdata_p1 != 16'h0)) mem_idle_bad++;
        if (mem_en_p1) mem_q.push_back('{cyc, mem_wr_p1, mem_addr_p1, mem_wdata_p1});
        if (if_rvalid_p1) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("FAIL if_resp_unexpected cyc=%0d got=%h want=none", cyc, if_rdata_p1);
            end else begin
                e = exp_if_q.pop_front();
                if (if_rdata_p1 !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL if_resp got=%h@%0d want=%h@%0d", if_rdata_p1, cyc, e.data, e.cyc);
                end
            end
        end
        if (ls_rvalid_p1) begin
            checks++;
            if (exp_ls_q.size() == 0) begin
                errors++;
                $display("FAIL ls_resp_unexpected cyc=%0d got=%h want=none", cyc, ls_rdata_p1);
            end else begin
                e = exp_ls_q.pop_front();
                if (ls_rdata_p1 !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ls_resp got=%h@%0d want=%h@%0d", ls_rdata_p1, cyc, e.data, e.cyc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_ls, input bit st, input logic [15:0] a,
                            input logic [15:0] wd, input int g);
        exp_t e;
        e.cyc  = g + int'(MEM_LAT) + 2;
        e.data = st ? 16'h0 : ref_read(a);
        if (st) begin
            ref_mem[a] = wd;
            ref_w[a]   = 1'b1;
        end
        if (is_ls) exp_ls_q.push_back(e);
        else       exp_if_q.push_back(e);
    endtask

    task automatic req_one(input bit is_ls, input bit st, input logic [15:0] a,
                           input logic [15:0] wd, input bit expect_resp, output int g);
        bit gi, gl;
        g = -1;
        if (is_ls) begin
            ls_req_p1 = 1'b1; ls_store_p1 = st; ls_addr_p1 = a; ls_wdata_p1 = wd;
        end else begin
            if_req_p1 = 1'b1; if_addr_p1 = a;
        end
        for (int i = 0; i < 64; i++) begin
            step(gi, gl);
            if (is_ls ? gl : gi) begin
                g = scyc;
                break;
            end
        end
        ls_req_p1 = 1'b0; ls_store_p1 = 1'b0; if_req_p1 = 1'b0;
        if (g >= 0 && expect_resp) push_exp(is_ls, st, a, wd, g);
    endtask

    task automatic drain(input int maxc);
        bit gi, gl;
        for (int i = 0; i < maxc; i++) begin
            if (exp_if_q.size() == 0 && exp_ls_q.size() == 0) break;
            step(gi, gl);
        end
        checks++;
        if (exp_if_q.size() != 0 || exp_ls_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending_if=%0d pending_ls=%0d want=0", exp_if_q.size(), exp_ls_q.size());
            exp_if_q.delete();
            exp_ls_q.delete();
        end
        for (int i = 0; i < 4; i++) step(gi, gl);
    endtask

    task automatic test_reset();
        bit gi, gl;
        step(gi, gl);
        step(gi, gl);
        checks++;
        if ({if_gnt_p1, if_rvalid_p1, if_rdata_p1, ls_gnt_p1, ls_rvalid_p1, ls_rdata_p1, mem_en_p1,
             mem_wr_p1, mem_addr_p1, mem_wdata_p1, busy_p1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got_busy=%b got_mem_en=%b want=all0", busy_p1, mem_en_p1);
        end
        rst = 1'b1;
        step(gi, gl);
        checks++;
        if (sbusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got=%b want=0", sbusy);
        end
    endtask

    task automatic test_fetch_single();
        int g;
        bit gi, gl;
        req_one(1'b0, 1'b0, 16'h0010, 16'h0, 1'b1, g);
        checks++;
        if (g < 0) begin
            errors++;
            $display("FAIL fetch_gnt got=timeout want=grant");
        end
        mem_q.delete();
        step(gi, gl);
        checks++;
        if (mem_q.size() != 1 || mem_q[0].cyc != g + 1 || mem_q[0].wr !== 1'b0 || mem_q[0].addr !== 16'h0010) begin
            errors++;
            $display("FAIL fetch_mem_en events=%0d want=1 strobe at cyc %0d addr 0010 rd", mem_q.size(), g + 1);
        end
        drain(40);
    endtask

    task automatic test_store_vs_fetch();
        int g, gf, gl2;
        bit gi, gl;
        ls_req_p1 = 1'b1; ls_store_p1 = 1'b1; ls_addr_p1 = 16'h0200; ls_wdata_p1 = 16'h1234;
        if_req_p1 = 1'b1; if_addr_p1 = 16'h0040;
        step(gi, gl);
        g = scyc;
        checks++;
        if (gl !== 1'b1 || gi !== 1'b0) begin
            errors++;
            $display("FAIL store_priority got ls_gnt=%b if_gnt=%b want ls_gnt=1 if_gnt=0", gl, gi);
        end
        if (gl) push_exp(1'b1, 1'b1, 16'h0200, 16'h1234, g);
        ls_req_p1 = 1'b0; ls_store_p1 = 1'b0;
        mem_q.delete();
        step(gi, gl);
        checks++;
        if (mem_q.size() != 1 || mem_q[0].wr !== 1'b1 || mem_q[0].addr !== 16'h0200 || mem_q[0].wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store_mem events=%0d want=1 write 0200<=1234", mem_q.size());
        end
        gf = -1;
        for (int i = 0; i < 40; i++) begin
            step(gi, gl);
            if (gi) begin
                gf = scyc;
                break;
            end
        end
        if_req_p1 = 1'b0;
        checks++;
        if (gf != g + int'(MEM_LAT) + 2) begin
            errors++;
            $display("FAIL fetch_gnt_in_resp got=%0d want=%0d", gf, g + int'(MEM_LAT) + 2);
        end
        if (gf >= 0) push_exp(1'b0, 1'b0, 16'h0040, 16'h0, gf);
        drain(40);
        req_one(1'b1, 1'b0, 16'h0200, 16'h0, 1'b1, gl2);
        drain(40);
    endtask

    task automatic test_flush();
        int g, gidle;
        bit gi, gl;
        req_one(1'b0, 1'b0, 16'h0050, 16'h0, 1'b0, g);
        if_flush_p1 = 1'b1;
        step(gi, gl);
        if_flush_p1 = 1'b0;
        gidle = -1;
        for (int i = 0; i < 40; i++) begin
            step(gi, gl);
            if (!sbusy) begin
                gidle = scyc;
                break;
            end
        end
        checks++;
        if (gidle != g + int'(MEM_LAT) + 3) begin
            errors++;
            $display("FAIL flush_busy_drop got=%0d want=%0d", gidle, g + int'(MEM_LAT) + 3);
        end
        req_one(1'b0, 1'b0, 16'h0060, 16'h0, 1'b1, g);
        drain(40);
        // data owner is immune to flush
        req_one(1'b1, 1'b0, 16'h0070, 16'h0, 1'b1, g);
        if_flush_p1 = 1'b1;
        step(gi, gl);
        if_flush_p1 = 1'b0;
        drain(40);
    endtask

    task automatic test_reset_mid();
        int g;
        bit gi, gl;
        req_one(1'b1, 1'b0, 16'h0111, 16'h0, 1'b1, g);
        step(gi, gl);
        rst = 1'b0;
        #1;
        checks++;
        if ({if_gnt_p1, if_rvalid_p1, if_rdata_p1, ls_gnt_p1, ls_rvalid_p1, ls_rdata_p1, mem_en_p1,
             mem_wr_p1, mem_addr_p1, mem_wdata_p1, busy_p1} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got_busy=%b want=all0", busy_p1);
        end
        exp_ls_q.delete();
        step(gi, gl);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(gi, gl);
        req_one(1'b1, 1'b0, 16'h0123, 16'h0, 1'b1, g);
        drain(40);
    endtask

    task automatic test_streak();
        string order, exp_order;
        int    ng;
        bit    gi, gl;
        order = "";
        exp_order = "";
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
            exp_order = {exp_order, ((k % (int'(MAX_STREAK) + 1)) == int'(MAX_STREAK)) ? "F" : "D"};
`else
            exp_order = {exp_order, "D"};
`endif
        end
        ls_req_p1 = 1'b1; ls_store_p1 = 1'b0; ls_addr_p1 = 16'h0300;
        if_req_p1 = 1'b1; if_addr_p1 = 16'h0400;
        ng = 0;
        for (int i = 0; i < 400 && ng < 10; i++) begin
            step(gi, gl);
            if (gl) begin
                push_exp(1'b1, 1'b0, 16'h0300, 16'h0, scyc);
                order = {order, "D"};
                ng++;
            end else if (gi) begin
                push_exp(1'b0, 1'b0, 16'h0400, 16'h0, scyc);
                order = {order, "F"};
                ng++;
            end
        end
        ls_req_p1 = 1'b0; if_req_p1 = 1'b0;
        checks++;
        if (order != exp_order) begin
            errors++;
            $display("FAIL grant_order got=%s want=%s", order, exp_order);
        end
        drain(60);
    endtask

    initial begin
        test_reset();
        test_fetch_single();
        test_store_vs_fetch();
        test_flush();
        test_reset_mid();
        test_streak();
        checks++;
        if (mem_idle_bad != 0) begin
            errors++;
            $display("FAIL mem_idle_zero got=%0d cycles want=0", mem_idle_bad);
        end
        checks++;
        if (both_gnt != 0) begin
            errors++;
            $display("FAIL gnt_exclusive got=%0d cycles want=0", both_gnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
